ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline; consumes the ID->EX register outputs.
- Contains the operand forwarding muxes, a single-cycle ALU and branch/jump resolution.
- Contains a 32-iteration sequential divider for DIV/DIVU/REM/REMU.
- Results feed the EX->MEM register. `busy` goes to the hazard unit, which stalls IF/ID and flushes ID->EX while a divide runs.

---
 rtl/ex_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : RV32 execute stage - operand forwarding, single-cycle ALU,
//             branch/jump resolution and a sequential restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [4:0]      RdE,
    input  logic            valid_in,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      Funct3E,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [4:0]      RdOutE,
    output logic            valid_out,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_lat;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [CW-1:0]   shamt;
    logic [XLEN-1:0] alu_out;
    logic            br_cond;
    logic            is_div;
    logic            issue;
    logic            op_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] next_quo;
    logic [XLEN-1:0] fixed_q;
    logic [XLEN-1:0] fixed_r;

    // Operand forwarding muxes and immediate select
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
        src_b = ALUSrcE ? ImmExtE : fwd_b;
        shamt = src_b[CW-1:0];
    end

    // Single-cycle ALU; divide encodings produce 0 here
    always_comb begin
        case (ALUControlE)
            4'b0000: alu_out = src_a + src_b;
            4'b0001: alu_out = src_a - src_b;
            4'b0010: alu_out = src_a & src_b;
            4'b0011: alu_out = src_a | src_b;
            4'b0100: alu_out = src_a ^ src_b;
            4'b0101: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0110: alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0111: alu_out = src_a << shamt;
            4'b1000: alu_out = src_a >> shamt;
            4'b1001: alu_out = $unsigned($signed(src_a) >>> shamt);
            4'b1010: alu_out = src_b;
            default: alu_out = '0;
        endcase
    end

    // Branch condition on the forwarded register operands
    always_comb begin
        case (Funct3E)
            3'b000:  br_cond = (src_a == fwd_b);
            3'b001:  br_cond = (src_a != fwd_b);
            3'b100:  br_cond = ($signed(src_a) < $signed(fwd_b));
            3'b101:  br_cond = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  br_cond = (src_a < fwd_b);
            3'b111:  br_cond = (src_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    // Divide issue detection, operand magnitudes and one restoring step
    always_comb begin
        is_div    = (ALUControlE[3:2] == 2'b11);
        issue     = (state == IDLE) && valid_in && is_div;
        op_signed = ~ALUControlE[0];
        abs_a     = (op_signed && src_a[XLEN-1]) ? (~src_a + 1'b1) : src_a;
        abs_b     = (op_signed && src_b[XLEN-1]) ? (~src_b + 1'b1) : src_b;
        rem_shift = {rem, quo[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor};
        if (!diff[XLEN]) begin
            next_rem = diff[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            next_rem = rem_shift[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end
        // A zero divisor leaves |dividend| as remainder; the quotient is forced
        fixed_q = div_zero ? '1 : (neg_q ? (~next_quo + 1'b1) : next_quo);
        fixed_r = neg_r ? (~next_rem + 1'b1) : next_rem;
    end

    // Divider FSM: latch operands on issue, iterate XLEN steps, present once
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            result   <= '0;
            rd_lat   <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        quo      <= abs_a;
                        rem      <= '0;
                        divisor  <= abs_b;
                        rd_lat   <= RdE;
                        is_rem   <= ALUControlE[1];
                        neg_q    <= op_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                        neg_r    <= op_signed && src_a[XLEN-1];
                        div_zero <= (src_b == '0);
                        count    <= CW'(XLEN-1);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    quo   <= next_quo;
                    rem   <= next_rem;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        result <= is_rem ? fixed_r : fixed_q;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output selection: combinational ALU path in IDLE, registered divide in DONE
    always_comb begin
        WriteDataE = fwd_b;
        PCTargetE  = JalrE ? ((src_a + ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                           : (PCE + ImmExtE);
        PCSrcE     = 1'b0;
        busy       = 1'b0;
        valid_out  = 1'b0;
        ALUResultE = '0;
        RdOutE     = '0;
        case (state)
            IDLE: begin
                PCSrcE     = valid_in && (JumpE || (BranchE && br_cond));
                busy       = issue;
                valid_out  = valid_in && !is_div;
                ALUResultE = alu_out;
                RdOutE     = RdE;
            end
            RUN: begin
                busy = 1'b1;
            end
            DONE: begin
                valid_out  = 1'b1;
                ALUResultE = result;
                RdOutE     = rd_lat;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage (reference model + directed).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, ALUResultM, ResultW;
    logic [4:0]  RdE;
    logic        valid_in, ALUSrcE, BranchE, JumpE, JalrE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE;
    logic [4:0]  RdOutE;
    logic        valid_out, PCSrcE, busy;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .RdE(RdE), .valid_in(valid_in), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E), .BranchE(BranchE),
        .JumpE(JumpE), .JalrE(JalrE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .RdOutE(RdOutE), .valid_out(valid_out),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] w, input logic [31:0] m);
        if (s == 2'b01) return w;
        if (s == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return sa >>> b[4:0];
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] div_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return op[1] ? 32'd0 : 32'h80000000;
        if (!op[0]) return op[1] ? (sa % sb) : (sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic logic br_ref(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Model state: a divide in flight, counted in cycles since issue
    logic        started = 1'b0;
    logic        pending = 1'b0;
    int          age = 0;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;

    always @(posedge clk) begin
        logic [31:0] a, b;
        a = fwd(ForwardAE, RD1E, ResultW, ALUResultM);
        b = ALUSrcE ? ImmExtE : fwd(ForwardBE, RD2E, ResultW, ALUResultM);
        if (!reset) begin
            pending = 1'b0;
            started = 1'b1;
        end else if (pending) begin
            if (age == 33) pending = 1'b0;
            else age++;
        end else if (valid_in && ALUControlE[3:2] == 2'b11) begin
            pending = 1'b1;
            age     = 1;
            exp_res = div_ref(ALUControlE, a, b);
            exp_rd  = RdE;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] a, fb, b, tgt;
        logic        isdiv;
        if (started) begin
            a   = fwd(ForwardAE, RD1E, ResultW, ALUResultM);
            fb  = fwd(ForwardBE, RD2E, ResultW, ALUResultM);
            b   = ALUSrcE ? ImmExtE : fb;
            tgt = JalrE ? ((a + ImmExtE) & 32'hFFFFFFFE) : (PCE + ImmExtE);
            check("m_wdata", WriteDataE, fb);
            check("m_target", PCTargetE, tgt);
            if (pending && age == 33) begin
                check("m_busy", {31'd0, busy}, 32'd0);
                check("m_valid", {31'd0, valid_out}, 32'd1);
                check("m_pcsrc", {31'd0, PCSrcE}, 32'd0);
                check("m_divres", ALUResultE, exp_res);
                check("m_divrd", {27'd0, RdOutE}, {27'd0, exp_rd});
            end else if (pending) begin
                check("m_busy", {31'd0, busy}, 32'd1);
                check("m_valid", {31'd0, valid_out}, 32'd0);
                check("m_pcsrc", {31'd0, PCSrcE}, 32'd0);
            end else begin
                isdiv = (ALUControlE[3:2] == 2'b11);
                check("m_busy", {31'd0, busy}, {31'd0, valid_in & isdiv});
                check("m_valid", {31'd0, valid_out}, {31'd0, valid_in & ~isdiv});
                check("m_pcsrc", {31'd0, PCSrcE},
                      {31'd0, valid_in & (JumpE | (BranchE & br_ref(Funct3E, a, fb)))});
                if (valid_in && !isdiv) begin
                    check("m_alures", ALUResultE, alu_ref(ALUControlE, a, b));
                    check("m_rd", {27'd0, RdOutE}, {27'd0, RdE});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; ALUResultM = 0; ResultW = 0;
        RdE = 0; valid_in = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
        ALUControlE = 0; Funct3E = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name);
        int lat;
        @(posedge clk); #1;
        clear_inputs();
        RD1E = a; RD2E = b; ALUControlE = op; RdE = 5'd9; valid_in = 1;
        @(negedge clk);
        check({name, "_busy_issue"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, lat, 32'd33);
        check({name, "_result"}, ALUResultE, exp);
        check({name, "_rd"}, {27'd0, RdOutE}, 32'd9);
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_rd", {27'd0, RdOutE}, 32'd0);

        // SUB with operand B forwarded from MEM
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 5; ForwardBE = 2'b10; ALUResultM = 3; ALUControlE = 4'b0001; RdE = 5'd3; valid_in = 1;
        @(negedge clk);
        check("sub_fwd", ALUResultE, 32'd2);
        check("sub_valid", {31'd0, valid_out}, 32'd1);

        // BEQ taken
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 7; RD2E = 7; PCE = 32'h100; ImmExtE = 32'h20; BranchE = 1; valid_in = 1;
        @(negedge clk);
        check("beq_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'h120);
        @(posedge clk); #1;
        valid_in = 0;
        @(negedge clk);
        check("beq_bubble_pcsrc", {31'd0, PCSrcE}, 32'd0);

        // JALR target with bit 0 cleared
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 32'h1003; ImmExtE = 4; JumpE = 1; JalrE = 1; valid_in = 1;
        @(negedge clk);
        check("jalr_target", PCTargetE, 32'h1006);
        check("jalr_pcsrc", {31'd0, PCSrcE}, 32'd1);

        // SRA with immediate shift amount, A forwarded from WB
        @(posedge clk); #1;
        clear_inputs();
        ForwardAE = 2'b01; ResultW = 32'h80000000; ALUSrcE = 1; ImmExtE = 4;
        ALUControlE = 4'b1001; valid_in = 1;
        @(negedge clk);
        check("sra_wb", ALUResultE, 32'hF8000000);

        // BLT taken on signed compare; SLT result
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 32'hFFFFFFFF; RD2E = 1; BranchE = 1; Funct3E = 3'b100;
        ALUControlE = 4'b0101; valid_in = 1;
        @(negedge clk);
        check("blt_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("slt_res", ALUResultE, 32'd1);

        // BLTU not taken on the same operands; SLTU result
        @(posedge clk); #1;
        Funct3E = 3'b110; ALUControlE = 4'b0110;
        @(negedge clk);
        check("bltu_pcsrc", {31'd0, PCSrcE}, 32'd0);
        check("sltu_res", ALUResultE, 32'd0);

        // Reserved encoding yields zero
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 32'h1234; RD2E = 32'h5678; ALUControlE = 4'b1011; valid_in = 1;
        @(negedge clk);
        check("reserved_res", ALUResultE, 32'd0);

        // Divides
        run_div(4'b1100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
        run_div(4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
        run_div(4'b1101, 32'd9, 32'd0, 32'hFFFFFFFF, "divu_9_0");
        run_div(4'b1111, 32'd9, 32'd0, 32'd9, "remu_9_0");
        run_div(4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_div(4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
        run_div(4'b1101, 32'd100, 32'd7, 32'd14, "divu_100_7");
        run_div(4'b1110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_m7_0");
        run_div(4'b1100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2");

        // Reset during RUN discards the divide
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 32'd1000; RD2E = 32'd3; ALUControlE = 4'b1101; RdE = 5'd4; valid_in = 1;
        @(posedge clk); #1;
        clear_inputs();
        repeat (9) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_valid", {31'd0, valid_out}, 32'd0);
        check("rst_run_res", ALUResultE, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        RD1E = 1; RD2E = 1; RdE = 5'd2; valid_in = 1;
        @(negedge clk);
        check("add_after_rst", ALUResultE, 32'd2);
        check("add_after_rst_valid", {31'd0, valid_out}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
